comp_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit comparator `comp_32`. Branch-resolution and compare requesters each raise a request carrying two operands and a tag. The block grants one requester at a time, drives `comp_32` from registered operands, captures `isNotEqual`/`isLessThan`, and returns the result to the winning requester over a valid/ack handshake. It sits between the decode/branch logic and the single comparator instance, so no second comparator is needed.

---
 rtl/comp_arb_pkg.sv | 17 +
 rtl/comp_32.sv | 21 ++
 rtl/comp_arb.sv | 134 +++++++++++++
 tb/tb_comp_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/comp_arb_pkg.sv
// Shared definitions for the comp_arb comparator arbiter: state encodings,
// default widths and requester ids.
package comp_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int TAG_W_DEFAULT  = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/comp_32.sv
// Shared 32-bit comparator: reports operand inequality and signed less-than,
// both forced low while the comparator is not enabled.
module comp_32 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        enable,
  output logic        isNotEqual,
  output logic        isLessThan
);

  logic signsDiffer;
  logic magLess;

  assign signsDiffer = in0[31] ^ in1[31];
  assign magLess     = in0[30:0] < in1[30:0];

  // With differing signs the negative operand is the smaller one.
  assign isNotEqual = enable && (in0 != in1);
  assign isLessThan = enable && (signsDiffer ? in0[31] : magLess);

endmodule

// File: rtl/comp_arb.sv
// Two-requester arbiter/sequencer in front of the single comp_32 instance.
// Define COMP_ARB_RR_EN for round-robin priority; otherwise requester 0 always wins.
module comp_arb
  import comp_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int TAG_W  = TAG_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] in0_0,
  input  logic [DATA_W-1:0] in0_1,
  input  logic [DATA_W-1:0] in1_0,
  input  logic [DATA_W-1:0] in1_1,
  input  logic [TAG_W-1:0]  tag_0,
  input  logic [TAG_W-1:0]  tag_1,
  output logic              ready_0,
  output logic              ready_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ack_0,
  input  logic              resp_ack_1,
  output logic              resp_neq,
  output logic              resp_lt,
  output logic [TAG_W-1:0]  resp_tag
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              owner_q, owner_d;
  logic              neq_q, neq_d, lt_q, lt_d;

  logic grant0, grant1;
  logic accept, acceptId;
  logic ownerAck;
  logic cmpEnable, cmpNeq, cmpLt;

`ifdef COMP_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign grant0 = req_0 && (!req_1 || ptr_q == REQ0);
  assign grant1 = req_1 && (!req_0 || ptr_q == REQ1);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (acceptId == REQ0) ? REQ1 : REQ0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= REQ0;
    else       ptr_q <= ptr_d;
  end
`else
  assign grant0 = req_0;
  assign grant1 = req_1 && !req_0;
`endif

  // Grants are withheld while reset is held so nothing looks accepted.
  assign ready_0  = (state_q == ST_IDLE) && grant0 && !reset;
  assign ready_1  = (state_q == ST_IDLE) && grant1 && !reset;
  assign accept   = ready_0 || ready_1;
  assign acceptId = ready_1 ? REQ1 : REQ0;
  assign ownerAck = (owner_q == REQ0) ? resp_ack_0 : resp_ack_1;

  assign resp_valid_0 = (state_q == ST_RESP) && (owner_q == REQ0);
  assign resp_valid_1 = (state_q == ST_RESP) && (owner_q == REQ1);
  assign resp_neq     = neq_q;
  assign resp_lt      = lt_q;
  assign resp_tag     = tag_q;

  comp_32 u_comp (
    .in0        (a_q),
    .in1        (b_q),
    .enable     (cmpEnable),
    .isNotEqual (cmpNeq),
    .isLessThan (cmpLt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    owner_d   = owner_q;
    neq_d     = neq_q;
    lt_d      = lt_q;
    cmpEnable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = (acceptId == REQ1) ? in0_1 : in0_0;
          b_d     = (acceptId == REQ1) ? in1_1 : in1_0;
          tag_d   = (acceptId == REQ1) ? tag_1 : tag_0;
          owner_d = acceptId;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cmpEnable = 1'b1;
        neq_d     = cmpNeq;
        lt_d      = cmpLt;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (ownerAck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      owner_q <= REQ0;
      neq_q   <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      owner_q <= owner_d;
      neq_q   <= neq_d;
      lt_q    <= lt_d;
    end
  end

endmodule

// File: tb/tb_comp_arb.sv
// Self-checking bench for comp_arb: directed cases plus randomized transactions
// checked against a transaction-level model of grant order and compare results.
module tb_comp_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_0, req_1;
  logic [31:0] in0_0, in0_1, in1_0, in1_1;
  logic [3:0]  tag_0, tag_1;
  logic        ready_0, ready_1;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ack_0, resp_ack_1;
  logic        resp_neq, resp_lt;
  logic [3:0]  resp_tag;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] opA [2];
  logic [31:0] opB [2];
  logic [3:0]  opTag [2];
  int          rrPtr;

  comp_arb #(.DATA_W(32), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .in0_0(in0_0), .in0_1(in0_1), .in1_0(in1_0), .in1_1(in1_1),
    .tag_0(tag_0), .tag_1(tag_1),
    .ready_0(ready_0), .ready_1(ready_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ack_0(resp_ack_0), .resp_ack_1(resp_ack_1),
    .resp_neq(resp_neq), .resp_lt(resp_lt), .resp_tag(resp_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", name, observed, expected);
  endtask

  // Grant rule from the priority policy, independent of any state encoding.
  function automatic int expectWinner(input logic [1:0] reqs);
    if (reqs == 2'b01) return 0;
    if (reqs == 2'b10) return 1;
`ifdef COMP_ARB_RR_EN
    return rrPtr;
`else
    return 0;
`endif
  endfunction

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_valid0"}, resp_valid_0, 0);
    checkOutput({name, "_valid1"}, resp_valid_1, 0);
  endtask

  // One full transaction: request, compare, response held ackDelay extra cycles.
  task automatic applyStimulus(input logic [1:0] reqs, input int ackDelay, input bit earlyAck);
    int   w;
    logic expNeq, expLt;
    w      = expectWinner(reqs);
    expNeq = (opA[w] != opB[w]);
    expLt  = ($signed(opA[w]) < $signed(opB[w]));
    in0_0 = opA[0]; in1_0 = opB[0]; tag_0 = opTag[0];
    in0_1 = opA[1]; in1_1 = opB[1]; tag_1 = opTag[1];
    req_0 = reqs[0]; req_1 = reqs[1];
    #1;
    checkOutput("grant_ready0", ready_0, (w == 0));
    checkOutput("grant_ready1", ready_1, (w == 1));
    rrPtr = 1 - w;
    @(posedge clock); #1;
    if (w == 0) req_0 = 1'b0; else req_1 = 1'b0;
    if (earlyAck) begin
      if (w == 0) resp_ack_0 = 1'b1; else resp_ack_1 = 1'b1;
    end
    #1;
    checkOutput("cmp_ready0", ready_0, 0);
    checkOutput("cmp_ready1", ready_1, 0);
    checkIdleOutputs("cmp");
    @(posedge clock); #1;
    resp_ack_0 = 1'b0; resp_ack_1 = 1'b0;
    if (ackDelay > 0) begin
      if (w == 0) resp_ack_1 = 1'b1; else resp_ack_0 = 1'b1;
    end
    #1;
    for (int c = 0; c <= ackDelay; c++) begin
      checkOutput("resp_valid0", resp_valid_0, (w == 0));
      checkOutput("resp_valid1", resp_valid_1, (w == 1));
      checkOutput("resp_neq", resp_neq, expNeq);
      checkOutput("resp_lt", resp_lt, expLt);
      checkOutput("resp_tag", resp_tag, opTag[w]);
      checkOutput("resp_ready0", ready_0, 0);
      checkOutput("resp_ready1", ready_1, 0);
      if (c == ackDelay) break;
      @(posedge clock); #1;
    end
    resp_ack_0 = (w == 0);
    resp_ack_1 = (w == 1);
    @(posedge clock); #1;
    resp_ack_0 = 1'b0; resp_ack_1 = 1'b0;
    #1;
    checkIdleOutputs("after_ack");
  endtask

  task automatic randomOperands(input int idx);
    case ($urandom_range(0, 3))
      0: begin opA[idx] = $urandom; opB[idx] = opA[idx]; end
      1: begin opA[idx] = $urandom; opB[idx] = $urandom; end
      2: begin
        opA[idx] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        opB[idx] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      default: begin opA[idx] = $urandom_range(0, 7); opB[idx] = $urandom_range(0, 7); end
    endcase
    opTag[idx] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    reset = 1'b1;
    req_0 = 1'b1; req_1 = 1'b1;
    in0_0 = '0; in0_1 = '0; in1_0 = '0; in1_1 = '0;
    tag_0 = '0; tag_1 = '0;
    resp_ack_0 = 1'b0; resp_ack_1 = 1'b0;
    rrPtr = 0;
    #2;
    checkOutput("rst_ready0", ready_0, 0);
    checkOutput("rst_ready1", ready_1, 0);
    checkOutput("rst_valid0", resp_valid_0, 0);
    checkOutput("rst_valid1", resp_valid_1, 0);
    checkOutput("rst_neq", resp_neq, 0);
    checkOutput("rst_lt", resp_lt, 0);
    checkOutput("rst_tag", resp_tag, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    #1;
    checkOutput("idle_ready0", ready_0, 0);
    checkOutput("idle_ready1", ready_1, 0);

    $display("[TB] equal operands");
    opA[0] = 45; opB[0] = 45; opTag[0] = 4'd3;
    opA[1] = 0;  opB[1] = 0;  opTag[1] = 4'd0;
    applyStimulus(2'b01, 0, 1'b0);

    $display("[TB] less-than on requester 1");
    opA[1] = 87; opB[1] = 458; opTag[1] = 4'd9;
    applyStimulus(2'b10, 1, 1'b0);

    $display("[TB] signed compares");
    opA[0] = 32'hFFFF_FFFF; opB[0] = 1; opTag[0] = 4'd5;
    applyStimulus(2'b01, 0, 1'b0);
    opA[1] = 1; opB[1] = 32'hFFFF_FFFF; opTag[1] = 4'd6;
    applyStimulus(2'b10, 0, 1'b0);

    $display("[TB] contention");
    rrPtr = 1;
    opA[0] = 1; opB[0] = 1; opTag[0] = 4'd1;
    applyStimulus(2'b10, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      randomOperands(0);
      randomOperands(1);
      applyStimulus(2'b11, 0, 1'b0);
    end

    $display("[TB] backpressure");
    opA[0] = 32'h1234_5678; opB[0] = 32'h1234_5679; opTag[0] = 4'd12;
    applyStimulus(2'b01, 5, 1'b0);

    $display("[TB] reset during compare");
    opA[1] = 32'h0000_0010; opB[1] = 32'h0000_0020; opTag[1] = 4'd7;
    in0_1 = opA[1]; in1_1 = opB[1]; tag_1 = opTag[1];
    req_0 = 1'b0; req_1 = 1'b1;
    #1;
    checkOutput("pre_rst_ready1", ready_1, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ready0", ready_0, 0);
    checkOutput("midrst_ready1", ready_1, 0);
    checkOutput("midrst_valid0", resp_valid_0, 0);
    checkOutput("midrst_valid1", resp_valid_1, 0);
    checkOutput("midrst_neq", resp_neq, 0);
    checkOutput("midrst_lt", resp_lt, 0);
    checkOutput("midrst_tag", resp_tag, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    rrPtr = 0;
    #1;
    checkIdleOutputs("post_rst");
    applyStimulus(2'b10, 0, 1'b0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 30; i++) begin
      logic [1:0] reqs;
      reqs = 2'($urandom_range(1, 3));
      randomOperands(0);
      randomOperands(1);
      applyStimulus(reqs, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
